// File: rtl/charlcd_responder.sv
// rtl/charlcd_responder.sv - HD44780-compatible character-LCD responder with DDRAM, busy timing and debug port
module charlcd_responder #(
    parameter int BUSY_CYCLES = 370,
    parameter int CLR_CYCLES  = 15200
) (
    input  logic       LCDCLK,
    input  logic       PRESETn,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [7:0] LCD_DATA,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE,
    input  logic [6:0] DBG_ADDR,
    output logic [7:0] DBG_CHAR,
    output logic       BUSY,
    output logic [6:0] ADDR_CNT,
    output logic       DISP_ON,
    output logic       CURSOR_ON,
    output logic       BLINK_ON,
    output logic       ENTRY_ID,
    output logic       ENTRY_S,
    output logic [2:0] FUNC_BITS,
    output logic [5:0] SHIFT_OFS,
    output logic       PROTO_ERR
);

    localparam int CNT_MAX = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_RESET_CLR, ST_IDLE, ST_CLEAR, ST_BUSY} state_t;

    state_t          state;
    logic [6:0]      sweep_idx;
    logic [CW-1:0]   cnt;
    logic [7:0]      ddram [0:79];

    logic            rs_s1, rs_s2, rw_s1, rw_s2;
    logic            en_s1, en_s2, en_s3;
    logic [7:0]      data_s1, data_s2;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        if (up)
            ac_step = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            ac_step = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic up);
        if (up)
            ofs_step = (o == 6'd39) ? 6'd0 : o + 6'd1;
        else
            ofs_step = (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

    function automatic logic addr_valid(input logic [6:0] a);
        addr_valid = (a[5:0] < 6'd40);
    endfunction

    // Line 2 (bit 6 set) occupies storage indices 40..79.
    function automatic logic [6:0] ddram_idx(input logic [6:0] a);
        ddram_idx = a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    endfunction

    always_ff @(posedge LCDCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rs_s1   <= 1'b0;
            rs_s2   <= 1'b0;
            rw_s1   <= 1'b0;
            rw_s2   <= 1'b0;
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            en_s3   <= 1'b0;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            rs_s1   <= LCD_RS;
            rs_s2   <= rs_s1;
            rw_s1   <= LCD_RW;
            rw_s2   <= rw_s1;
            en_s1   <= LCD_EN;
            en_s2   <= en_s1;
            en_s3   <= en_s2;
            data_s1 <= LCD_DATA;
            data_s2 <= data_s1;
        end
    end

    logic       fall, is_status, sweeping, data_wr, mem_we;
    logic [6:0] mem_idx;
    logic [7:0] mem_wdata;

    always_comb begin
        fall      = en_s3 & ~en_s2;
        is_status = ~rs_s2 & rw_s2;
        sweeping  = (state == ST_RESET_CLR) || (state == ST_CLEAR);
        data_wr   = fall && (state == ST_IDLE) && rs_s2 && !rw_s2;
        mem_we    = sweeping || data_wr;
        mem_idx   = sweeping ? sweep_idx : ddram_idx(ADDR_CNT);
        mem_wdata = sweeping ? 8'h20 : data_s2;
    end

    // DDRAM has no reset: the power-on sweep initialises it instead.
    always_ff @(posedge LCDCLK) begin
        if (mem_we)
            ddram[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge LCDCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_RESET_CLR;
            sweep_idx <= 7'd0;
            cnt       <= '0;
            BUSY      <= 1'b1;
            ADDR_CNT  <= 7'h00;
            ENTRY_ID  <= 1'b1;
            ENTRY_S   <= 1'b0;
            DISP_ON   <= 1'b0;
            CURSOR_ON <= 1'b0;
            BLINK_ON  <= 1'b0;
            FUNC_BITS <= 3'b000;
            SHIFT_OFS <= 6'd0;
            PROTO_ERR <= 1'b0;
        end else begin
            case (state)
                ST_RESET_CLR, ST_CLEAR: begin
                    if (fall && !is_status)
                        PROTO_ERR <= 1'b1;
                    if (sweep_idx == 7'd79) begin
                        // The sweep itself consumes 80 of the CLR_CYCLES busy cycles.
                        if (CLR_CYCLES > 80) begin
                            state <= ST_BUSY;
                            cnt   <= CW'(CLR_CYCLES - 81);
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        sweep_idx <= sweep_idx + 7'd1;
                    end
                end
                ST_BUSY: begin
                    if (fall && !is_status)
                        PROTO_ERR <= 1'b1;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (fall && !is_status) begin
                        state <= ST_BUSY;
                        BUSY  <= 1'b1;
                        cnt   <= CW'(BUSY_CYCLES - 1);
                        if (rs_s2) begin
                            ADDR_CNT <= ac_step(ADDR_CNT, ENTRY_ID);
                            if (!rw_s2 && ENTRY_S)
                                SHIFT_OFS <= ofs_step(SHIFT_OFS, ENTRY_ID);
                        end else begin
                            casez (data_s2)
                                8'b1???????: begin
                                    if (addr_valid(data_s2[6:0]))
                                        ADDR_CNT <= data_s2[6:0];
                                    else
                                        PROTO_ERR <= 1'b1;
                                end
                                8'b01??????: ;
                                8'b001?????: FUNC_BITS <= data_s2[4:2];
                                8'b0001????: begin
                                    if (data_s2[3])
                                        SHIFT_OFS <= ofs_step(SHIFT_OFS, data_s2[2]);
                                    else
                                        ADDR_CNT <= ac_step(ADDR_CNT, data_s2[2]);
                                end
                                8'b00001???: begin
                                    DISP_ON   <= data_s2[2];
                                    CURSOR_ON <= data_s2[1];
                                    BLINK_ON  <= data_s2[0];
                                end
                                8'b000001??: begin
                                    ENTRY_ID <= data_s2[1];
                                    ENTRY_S  <= data_s2[0];
                                end
                                8'b0000001?: begin
                                    ADDR_CNT  <= 7'h00;
                                    SHIFT_OFS <= 6'd0;
                                    cnt       <= CW'(CLR_CYCLES - 1);
                                end
                                8'b00000001: begin
                                    state     <= ST_CLEAR;
                                    sweep_idx <= 7'd0;
                                    ADDR_CNT  <= 7'h00;
                                    ENTRY_ID  <= 1'b1;
                                    SHIFT_OFS <= 6'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge LCDCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            LCD_DATA_OE  <= 1'b0;
            LCD_DATA_OUT <= 8'h00;
            DBG_CHAR     <= 8'h00;
        end else begin
            LCD_DATA_OE <= en_s2 & rw_s2;
            if (en_s2 && rw_s2)
                LCD_DATA_OUT <= rs_s2 ? ddram[ddram_idx(ADDR_CNT)] : {BUSY, ADDR_CNT};
            DBG_CHAR <= addr_valid(DBG_ADDR) ? ddram[ddram_idx(DBG_ADDR)] : 8'h00;
        end
    end

endmodule

// File: tb/tb_charlcd_responder.sv
// tb/tb_charlcd_responder.sv - directed self-checking bench for charlcd_responder
module tb_charlcd_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_char;
    logic       busy;
    logic [6:0] addr_cnt;
    logic       disp_on, cursor_on, blink_on, entry_id, entry_s;
    logic [2:0] func_bits;
    logic [5:0] shift_ofs;
    logic       proto_err;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rd_val;
    logic       rd_oe;
    logic [7:0] peek_val;
    int         n;

    always #50 clk = ~clk;

    charlcd_responder dut (
        .LCDCLK      (clk),
        .PRESETn     (rst_n),
        .LCD_RS      (lcd_rs),
        .LCD_RW      (lcd_rw),
        .LCD_EN      (lcd_en),
        .LCD_DATA    (lcd_data),
        .LCD_DATA_OUT(lcd_data_out),
        .LCD_DATA_OE (lcd_data_oe),
        .DBG_ADDR    (dbg_addr),
        .DBG_CHAR    (dbg_char),
        .BUSY        (busy),
        .ADDR_CNT    (addr_cnt),
        .DISP_ON     (disp_on),
        .CURSOR_ON   (cursor_on),
        .BLINK_ON    (blink_on),
        .ENTRY_ID    (entry_id),
        .ENTRY_S     (entry_s),
        .FUNC_BITS   (func_bits),
        .SHIFT_OFS   (shift_ofs),
        .PROTO_ERR   (proto_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full bus cycle; captures OE and read data just before EN falls.
    task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d);
        @(negedge clk);
        lcd_rs   = r_s;
        lcd_rw   = r_w;
        lcd_data = d;
        lcd_en   = 1'b1;
        repeat (3) @(negedge clk);
        rd_oe  = lcd_data_oe;
        rd_val = lcd_data_out;
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rs = 1'b0;
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wr(input logic r_s, input logic [7:0] d);
        xfer(r_s, 1'b0, d);
        wait_idle("idle");
    endtask

    task automatic peek(input logic [6:0] a);
        @(negedge clk);
        dbg_addr = a;
        @(negedge clk);
        peek_val = dbg_char;
    endtask

    initial begin
        rst_n    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_en   = 1'b0;
        lcd_data = 8'h00;
        dbg_addr = 7'h00;
        repeat (3) @(negedge clk);

        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_ac", {25'd0, addr_cnt}, 32'h00);
        check_eq("rst_id", {31'd0, entry_id}, 32'd1);
        check_eq("rst_dcb_s", {28'd0, disp_on, cursor_on, blink_on, entry_s}, 32'd0);
        check_eq("rst_func_ofs", {23'd0, func_bits, shift_ofs}, 32'd0);
        check_eq("rst_err_oe", {30'd0, proto_err, lcd_data_oe}, 32'd0);
        check_eq("rst_dout_dbg", {16'd0, lcd_data_out, dbg_char}, 32'd0);

        rst_n = 1'b1;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("por_busy_len", n, 32'd15200);

        xfer(1'b0, 1'b1, 8'h00);
        check_eq("status_oe", {31'd0, rd_oe}, 32'd1);
        check_eq("status_val", {24'd0, rd_val}, 32'h00);
        check_eq("oe_drop", {31'd0, lcd_data_oe}, 32'd0);
        peek(7'h00); check_eq("por_dbg_00", {24'd0, peek_val}, 32'h20);
        peek(7'h27); check_eq("por_dbg_27", {24'd0, peek_val}, 32'h20);
        peek(7'h40); check_eq("por_dbg_40", {24'd0, peek_val}, 32'h20);
        peek(7'h67); check_eq("por_dbg_67", {24'd0, peek_val}, 32'h20);
        peek(7'h28); check_eq("dbg_invalid", {24'd0, peek_val}, 32'h00);

        xfer(1'b0, 1'b0, 8'h38);
        n = 1;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("instr_busy_len", n, 32'd370);
        wr(1'b0, 8'h0F);
        wr(1'b0, 8'h06);
        wr(1'b1, 8'h41);
        wr(1'b1, 8'h42);
        check_eq("func_bits", {29'd0, func_bits}, 32'b110);
        check_eq("dcb", {29'd0, disp_on, cursor_on, blink_on}, 32'b111);
        check_eq("entry", {30'd0, entry_id, entry_s}, 32'b10);
        check_eq("ac_after_ab", {25'd0, addr_cnt}, 32'h02);
        peek(7'h00); check_eq("ddram_00", {24'd0, peek_val}, 32'h41);
        peek(7'h01); check_eq("ddram_01", {24'd0, peek_val}, 32'h42);

        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h5A);
        peek(7'h27); check_eq("ddram_27", {24'd0, peek_val}, 32'h5A);
        check_eq("ac_wrap_27_40", {25'd0, addr_cnt}, 32'h40);

        wr(1'b0, 8'h04);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h33);
        check_eq("ac_wrap_00_67", {25'd0, addr_cnt}, 32'h67);
        peek(7'h00); check_eq("ddram_00_dec", {24'd0, peek_val}, 32'h33);
        wr(1'b0, 8'h18);
        wr(1'b0, 8'h18);
        check_eq("shift_ofs", {26'd0, shift_ofs}, 32'd38);
        check_eq("err_clean", {31'd0, proto_err}, 32'd0);

        xfer(1'b1, 1'b0, 8'h11);
        xfer(1'b1, 1'b0, 8'h22);
        wait_idle("idle_err");
        check_eq("err_busy_write", {31'd0, proto_err}, 32'd1);
        check_eq("ac_busy_write", {25'd0, addr_cnt}, 32'h66);
        peek(7'h67); check_eq("ddram_67", {24'd0, peek_val}, 32'h11);
        wr(1'b0, 8'hB0);
        check_eq("err_sticky", {31'd0, proto_err}, 32'd1);
        check_eq("ac_bad_addr", {25'd0, addr_cnt}, 32'h66);

        wr(1'b0, 8'h06);
        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h77);
        wr(1'b0, 8'hC0);
        xfer(1'b1, 1'b1, 8'h00);
        check_eq("dread_oe", {31'd0, rd_oe}, 32'd1);
        check_eq("dread_val", {24'd0, rd_val}, 32'h77);
        xfer(1'b0, 1'b1, 8'h00);
        check_eq("status_busy_val", {24'd0, rd_val}, 32'hC1);
        check_eq("oe_drop2", {31'd0, lcd_data_oe}, 32'd0);
        wait_idle("idle_rd");
        check_eq("ac_after_read", {25'd0, addr_cnt}, 32'h41);

        wr(1'b0, 8'h04);
        xfer(1'b0, 1'b0, 8'h01);
        check_eq("clr_id", {31'd0, entry_id}, 32'd1);
        check_eq("clr_ac", {25'd0, addr_cnt}, 32'h00);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midclr_rst", {30'd0, busy, proto_err}, 32'b10);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("idle_reclr");
        peek(7'h00); check_eq("reclr_00", {24'd0, peek_val}, 32'h20);
        peek(7'h27); check_eq("reclr_27", {24'd0, peek_val}, 32'h20);
        peek(7'h40); check_eq("reclr_40", {24'd0, peek_val}, 32'h20);
        peek(7'h67); check_eq("reclr_67", {24'd0, peek_val}, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
